// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, screen constants and sprite record for sprite_compositor
package sprite_pkg;
  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;
  localparam int H_VIS   = 1024;
  localparam int V_VIS   = 768;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [RGB_W-1:0]   color;
    logic               en;
  } sprite_t;
endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - one sprite channel: frame-coherent shadow register and registered range compare
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               load,
  input  logic               blank,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [RGB_W-1:0]   color_in,
  input  logic               en_in,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  output logic               hit,
  output logic [RGB_W-1:0]   color
);
  localparam logic [COORD_W:0] W_EXT = SPR_W[COORD_W:0];
  localparam logic [COORD_W:0] H_EXT = SPR_H[COORD_W:0];

  sprite_t          shadow;
  logic [COORD_W:0] x_lo, x_hi, y_lo, y_hi, h_ext, v_ext;
  logic             in_rect;

  // One extra bit keeps x+SPR_W from wrapping back onto the left edge
  assign x_lo    = {1'b0, shadow.x};
  assign y_lo    = {1'b0, shadow.y};
  assign x_hi    = x_lo + W_EXT;
  assign y_hi    = y_lo + H_EXT;
  assign h_ext   = {1'b0, hcount};
  assign v_ext   = {1'b0, vcount};
  assign in_rect = shadow.en & (h_ext >= x_lo) & (h_ext < x_hi) & (v_ext >= y_lo) & (v_ext < y_hi);
  assign color   = shadow.color;

  // Shadow copy only changes at the frame edge so a frame never tears
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) shadow <= '0;
    else if (load) shadow <= '{x: x_in, y: y_in, color: color_in, en: en_in};
  end

  // Stage-1 hit, suppressed in any blanking interval
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) hit <= 1'b0;
    else     hit <= in_rect & ~blank;
  end
endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - 2-cycle sprite overlay stage; collision monitor under SPRITE_COLLISION_EN
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         hcount_in,
  input  logic [COORD_W-1:0]         vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [RGB_W-1:0]           rgb_in,
  input  logic [N_SPR*COORD_W-1:0]   spr_x_in,
  input  logic [N_SPR*COORD_W-1:0]   spr_y_in,
  input  logic [N_SPR*RGB_W-1:0]     spr_color_in,
  input  logic [N_SPR-1:0]           spr_en_in,
  output logic [COORD_W-1:0]         hcount_out,
  output logic [COORD_W-1:0]         vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [RGB_W-1:0]           rgb_out,
  output logic [N_SPR-1:0]           coll_mask_out,
  output logic                       coll_valid_out
);
  logic                 vblnk_prev;
  logic                 frame_edge;
  logic [N_SPR-1:0]     hit;
  logic [RGB_W-1:0]     color_sh [N_SPR];
  logic [COORD_W-1:0]   hcount_d1, vcount_d1;
  logic                 hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
  logic [RGB_W-1:0]     rgb_d1, rgb_mux;

  assign frame_edge = vblnk_in & ~vblnk_prev;

  // Previous vblnk, used to spot the start of vertical blanking
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) vblnk_prev <= 1'b0;
    else     vblnk_prev <= vblnk_in;
  end

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .pclk     (pclk),
      .rst      (rst),
      .load     (frame_edge),
      .blank    (hblnk_in | vblnk_in),
      .x_in     (spr_x_in[COORD_W*i +: COORD_W]),
      .y_in     (spr_y_in[COORD_W*i +: COORD_W]),
      .color_in (spr_color_in[RGB_W*i +: RGB_W]),
      .en_in    (spr_en_in[i]),
      .hcount   (hcount_in),
      .vcount   (vcount_in),
      .hit      (hit[i]),
      .color    (color_sh[i])
    );
  end

  // Stage 1: carry timing and upstream pixel alongside the hit compares
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_d1 <= '0; vcount_d1 <= '0;
      hsync_d1  <= 1'b0; vsync_d1 <= 1'b0; hblnk_d1 <= 1'b0; vblnk_d1 <= 1'b0;
      rgb_d1    <= '0;
    end else begin
      hcount_d1 <= hcount_in; vcount_d1 <= vcount_in;
      hsync_d1  <= hsync_in;  vsync_d1  <= vsync_in;
      hblnk_d1  <= hblnk_in;  vblnk_d1  <= vblnk_in;
      rgb_d1    <= rgb_in;
    end
  end

  // Lowest-index hit wins; with no hit the upstream pixel passes through
  always_comb begin
    rgb_mux = rgb_d1;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) rgb_mux = color_sh[i];
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0; vcount_out <= '0;
      hsync_out  <= 1'b0; vsync_out <= 1'b0; hblnk_out <= 1'b0; vblnk_out <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d1; vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;  vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;  vblnk_out  <= vblnk_d1;
      rgb_out    <= rgb_mux;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] acc, acc_next;

  // Sprite 0 is the reference, so its own bit never accumulates
  always_comb begin
    acc_next    = acc | ({N_SPR{hit[0]}} & hit);
    acc_next[0] = 1'b0;
  end

  // Publish and clear the accumulator once per frame at the vblnk edge
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      coll_mask_out  <= '0;
      coll_valid_out <= 1'b0;
    end else begin
      coll_valid_out <= frame_edge;
      if (frame_edge) begin
        coll_mask_out <= acc;
        acc           <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end
`else
  assign coll_mask_out  = '0;
  assign coll_valid_out = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized and directed check of sprite_compositor against a frame-level model
module tb_sprite_compositor;
  localparam int N = 4;
  localparam int W = 16;
  localparam int H = 16;
`ifdef SPRITE_COLLISION_EN
  localparam logic [3:0] EXP_OVL = 4'b1000;
`else
  localparam logic [3:0] EXP_OVL = 4'b0000;
`endif

  logic pclk = 1'b0;
  logic rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [N*11-1:0] spr_x_in, spr_y_in;
  logic [N*12-1:0] spr_color_in;
  logic [N-1:0] spr_en_in;
  logic [N-1:0] coll_mask_out;
  logic coll_valid_out;

  always #5 pclk = ~pclk;

  sprite_compositor #(.N_SPR(N), .SPR_W(W), .SPR_H(H)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .spr_x_in(spr_x_in), .spr_y_in(spr_y_in), .spr_color_in(spr_color_in), .spr_en_in(spr_en_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .coll_mask_out(coll_mask_out), .coll_valid_out(coll_valid_out)
  );

  // sprite inputs as driven, and the model's frame-coherent copy
  int sx[N], sy[N], scol[N];
  bit sen[N];
  int hx[N], hy[N], hcol[N];
  bit hen[N];

  always_comb begin
    spr_x_in = '0; spr_y_in = '0; spr_color_in = '0; spr_en_in = '0;
    for (int i = 0; i < N; i++) begin
      spr_x_in[11*i +: 11]     = sx[i][10:0];
      spr_y_in[11*i +: 11]     = sy[i][10:0];
      spr_color_in[12*i +: 12] = scol[i][11:0];
      spr_en_in[i]             = sen[i];
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  logic [37:0] exp_d1, exp_d2;
  bit prev_vb;
  logic [3:0] acc_m, mask_m;
  bit valid_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_d1 = '0; exp_d2 = '0; prev_vb = 1'b0;
    acc_m = '0; mask_m = '0; valid_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      hx[i] = 0; hy[i] = 0; hcol[i] = 0; hen[i] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, 64'(rgb_out), 64'd0);
    chk({tag, "_timing"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'd0);
    chk({tag, "_mask"}, 64'(coll_mask_out), 64'd0);
    chk({tag, "_valid"}, 64'(coll_valid_out), 64'd0);
  endtask

  function automatic bit mhit(int i, int h, int v, bit hb, bit vb);
    return hen[i] && !hb && !vb && h >= hx[i] && h < hx[i] + W && v >= hy[i] && v < hy[i] + H;
  endfunction

  // drive one pixel, advance one clock, compare against the model
  task automatic step(input int h, input int v, input bit hb, input bit vb);
    logic [11:0] rgb;
    logic hs, vs, edge_now;
    logic [3:0] hits;
    logic [11:0] exp_rgb;
    int win;
    rgb = 12'($urandom); hs = 1'($urandom); vs = 1'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = vb;
    hsync_in = hs; vsync_in = vs; rgb_in = rgb;
    win = -1;
    for (int i = 0; i < N; i++) begin
      hits[i] = mhit(i, h, v, hb, vb);
      if (win < 0 && hits[i]) win = i;
    end
    exp_rgb = (win >= 0) ? hcol[win][11:0] : rgb;
    edge_now = vb && !prev_vb;
    prev_vb = vb;
`ifdef SPRITE_COLLISION_EN
    if (edge_now) begin
      mask_m = acc_m; acc_m = '0;
    end else if (hits[0]) begin
      acc_m = acc_m | {hits[3:1], 1'b0};
    end
    valid_m = edge_now;
`endif
    if (edge_now) begin
      for (int i = 0; i < N; i++) begin
        hx[i] = sx[i]; hy[i] = sy[i]; hcol[i] = scol[i] & 12'hFFF; hen[i] = sen[i];
      end
    end
    @(posedge pclk); #1;
    exp_d2 = exp_d1;
    exp_d1 = {11'(h), 11'(v), hs, vs, hb, vb, exp_rgb};
    chk("rgb", 64'(rgb_out), 64'(exp_d2[11:0]));
    chk("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'(exp_d2[37:12]));
    chk("coll_mask", 64'(coll_mask_out), 64'(mask_m));
    chk("coll_valid", 64'(coll_valid_out), 64'(valid_m));
  endtask

  task automatic vblank_edge();
    step(1100, 767, 1, 0);
    step(1101, 767, 1, 0);
    step(0, 768, 1, 1);
    step(1, 768, 1, 1);
    step(2, 769, 1, 1);
  endtask

  task automatic scan(input int h0, input int h1, input int v);
    for (int h = h0; h <= h1; h++) step(h, v, h >= 1024, 0);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int c, input bit en);
    sx[i] = x; sy[i] = y; scol[i] = c; sen[i] = en;
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    for (int i = 0; i < N; i++) set_spr(i, 0, 0, 0, 0);
    set_spr(0, 100, 200, 12'hF00, 1);
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    chk_zero("reset_init");
    rst = 1'b0;

    // before any frame edge nothing draws, even over the sprite's area
    scan(95, 120, 200);
    rst = 1'b1; #1;
    chk_zero("reset_mid");
    @(posedge pclk); #1;
    rst = 1'b0;
    model_reset();
    scan(95, 120, 205);

    // single sprite, including first/last rows and columns
    vblank_edge();
    scan(98, 117, 199);
    scan(98, 117, 200);
    scan(98, 117, 215);
    scan(98, 117, 216);

    // priority between overlapping channels
    set_spr(0, 300, 300, 12'h0F0, 1);
    set_spr(2, 308, 308, 12'h00F, 1);
    vblank_edge();
    for (int v = 300; v <= 325; v += 5) scan(298, 326, v);

    // tear-free position change mid-frame
    set_spr(2, 0, 0, 0, 0);
    set_spr(0, 100, 40, 12'hF00, 1);
    vblank_edge();
    scan(98, 118, 50);
    sx[0] = 400;
    scan(98, 118, 52);
    scan(398, 418, 52);
    vblank_edge();
    scan(98, 118, 52);
    scan(398, 418, 52);

    // collision report, then a frame without overlap
    set_spr(0, 500, 500, 12'h111, 1);
    set_spr(1, 50, 50, 12'h222, 1);
    set_spr(3, 510, 505, 12'h333, 1);
    vblank_edge();
    scan(498, 530, 500);
    scan(498, 530, 507);
    scan(45, 70, 55);
    vblank_edge();
    chk("coll_mask_overlap", 64'(coll_mask_out), 64'(EXP_OVL));
    set_spr(3, 700, 700, 12'h333, 1);
    scan(498, 530, 507);
    scan(695, 720, 705);
    vblank_edge();
    chk("coll_mask_clear", 64'(coll_mask_out), 64'd0);

    // right-edge clipping without wrap to x=0
    for (int i = 0; i < N; i++) set_spr(i, 0, 0, 0, 0);
    set_spr(1, 1020, 10, 12'hABC, 1);
    vblank_edge();
    scan(1016, 1040, 12);
    scan(0, 14, 12);

    // random sprite sets with pixels clustered near sprites
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++)
        set_spr(i, $urandom_range(0, 1100), $urandom_range(0, 760), $urandom_range(0, 4095), 1'($urandom_range(0, 3) != 0));
      if (f[0]) begin
        sx[3] = sx[0] + $urandom_range(0, 10); sy[3] = sy[0] + $urandom_range(0, 10);
      end
      vblank_edge();
      for (int n = 0; n < 300; n++) begin
        int k, h, v;
        k = $urandom_range(0, N - 1);
        h = sx[k] - 4 + $urandom_range(0, 24);
        v = sy[k] - 4 + $urandom_range(0, 24);
        if (h < 0) h = 0;
        if (h > 1343) h = 1343;
        if (v < 0) v = 0;
        if (v > 767) v = 767;
        step(h, v, h >= 1024, 0);
      end
    end
    vblank_edge();
    step(5, 5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel-pipeline stage that composites up to N_SPR solid rectangular sprites over the incoming VGA stream on the 65 MHz pixel clock. It sits between any two stages of the draw chain (background → ship → enemies → textbox), forwarding timing signals with a fixed 2-cycle latency. Sprite positions are frame-coherent: they are shadowed at the start of vertical blanking. An optional collision monitor reports, once per frame, which sprites overlapped sprite 0.

## Interface
Parameters:
- N_SPR, 4, number of sprite channels (1..8); channel 0 has highest priority and is the collision reference.
- SPR_W, 16, sprite width in pixels (1..255).
- SPR_H, 16, sprite height in pixels (1..255).

Ports:
- pclk  in  1  pixel clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- hcount_in, vcount_in  in  11 each  pixel coordinates.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals.
- rgb_in  in  12  upstream pixel, {r,g,b} at 4 bits per channel.
- spr_x_in, spr_y_in  in  N_SPR*11  sprite top-left corners; channel i occupies bits [11i+10:11i].
- spr_color_in  in  N_SPR*12  sprite colours.
- spr_en_in  in  N_SPR  per-channel enable.
- hcount_out, vcount_out  out  11 each  delayed timing.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited pixel.
- coll_mask_out  out  N_SPR  per-frame collision mask; bit 0 is always 0.
- coll_valid_out  out  1  one-cycle strobe marking a new coll_mask_out.

## Operation
- **Frame edge.**
  - A registered copy of vblnk_in detects the rising edge: vblnk_in=1 while the previous value was 0.
  - On the edge, spr_x/y/color/en are loaded into shadow registers.
  - Drawing uses only the shadow registers, so input changes mid-frame never tear the picture.
- **Stage 1 (per channel).**
  - hit_i = en_i & (hcount ≥ x_i) & (hcount < x_i+SPR_W) & (vcount ≥ y_i) & (vcount < y_i+SPR_H).
  - Sums are computed at 12 bits, so x_i+SPR_W never wraps. A sprite partially off-screen draws only its visible part.
  - All hits are forced to 0 while hblnk_in or vblnk_in is high.
- **Stage 2.**
  - rgb_out = color of the lowest-index asserted hit.
  - If no hit is asserted, rgb_out = rgb_in delayed by 2 cycles.
- **Collision (SPRITE_COLLISION_EN).**
  - Accumulator acc[i] |= hit_0 & hit_i for i ≥ 1; acc[0] is tied to 0.
  - On the frame edge: coll_mask_out ← acc, coll_valid_out ← 1 for exactly one cycle, then acc ← 0.
  - Hits are suppressed during blanking and the pipeline drains before vblnk rises, so an accumulate and a clear can never coincide.
- **Reset (any time).**
  - Every output becomes 0, including rgb_out, all timing outputs, coll_mask_out and coll_valid_out.
  - Shadow registers (including enables) and acc are cleared, so no sprite draws until the first frame edge after reset.
  - A reset mid-frame discards that frame's collision data.

## Timing
- Latency is exactly 2 pclk cycles from every *_in to the matching *_out. All outputs are registered.
- Shadow load: on an edge in cycle t, the shadow registers update at the end of t and take effect from cycle t+1.
- coll_valid_out is high in cycle t+1 only. coll_mask_out holds its value until the next frame edge.
- Throughput is one pixel per cycle with no stalls.

## Configuration
- Macro: SPRITE_COLLISION_EN.
- **Defined:** the accumulator and collision outputs are built as described under Operation.
- **Undefined:** no accumulator logic is built; coll_mask_out is tied to 0 and coll_valid_out to 0. Compositing is unchanged.

## Structure
- Shared package sprite_pkg holds:
  - COORD_W = 11 and RGB_W = 12;
  - visible-area constants H_VIS = 1024 and V_VIS = 768;
  - a packed sprite struct {x, y, color, en}.
- Sub-module sprite_hit: one channel's shadow register and registered range compare. It is instantiated N_SPR times in a generate loop.
- The priority mux, edge detect and collision accumulator stay in the top module.

## Test plan
- **Reset:** assert rst mid-line → all outputs become 0 immediately; after release, rgb_out = rgb_in delayed by 2 cycles until the first vblnk edge.
- **Single sprite:** sprite 0 at (100,200), color 12'hF00, enabled → rgb_out = F00 exactly for hcount 100..115 and vcount 200..215, each pixel appearing 2 cycles after its input.
- **Priority:** sprites 0 and 2 overlap at (300,300), colors 0F0 and 00F → overlapped pixels show 0F0; pixels covered only by sprite 2 show 00F.
- **Tear-free update:** change spr_x_in[0] from 100 to 400 at vcount 50 → the current frame still draws at x=100; the next frame draws at x=400.
- **Collision:** sprite 0 at (500,500) and sprite 3 at (510,505), sprite 1 far away → at the next vblnk edge coll_mask_out = 4'b1000 with a single-cycle coll_valid_out; the following frame, with no overlap, reports 4'b0000.
- **Edge clipping:** sprite at x=1020 → only hcount 1020..1023 are drawn, with no wrap-around to x=0..11.
